// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared definitions for the 4-source round-robin mux scheduler.
package mux4_rr_scheduler_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_e;

    // Binary source index to one-hot grant vector.
    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_scheduler_rr_pick4.sv
// Round-robin pick: first set request bit searching upward from last+1,
// wrapping after 3. Purely combinational.
module rr_pick4
    import mux4_rr_scheduler_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    // Walk candidates farthest-first so the nearest set bit after last wins.
    always_comb begin
        idx  = '0;
        pick = last;
        any  = |req;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = last + SEL_W'(k) + SEL_W'(1);
            if (req[idx]) pick = idx;
        end
    end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler for a shared 4:1, 1-bit mux line.
// Owners are separated by GUARD_CYCLES idle cycles with out_en low so the
// line never changes source while enabled.
// Optional: define MUX4_RR_TIMEOUT_EN to preempt an owner after MAX_HOLD
// consecutive grant cycles.
module mux4_rr_scheduler
    import mux4_rr_scheduler_pkg::*;
#(
    parameter int MAX_HOLD     = 64,
    parameter int GUARD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               out_en,
    output logic               busy
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD out of range 1..255");
    end
    if (GUARD_CYCLES < 0 || GUARD_CYCLES > 15) begin : g_bad_guard
        $error("GUARD_CYCLES out of range 0..15");
    end

    // Last guard count value before leaving GUARD (unused when GUARD_CYCLES=0).
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               out_en_q, out_en_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [3:0]         guard_cnt_q, guard_cnt_d;
`ifdef MUX4_RR_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0]         hold_cnt_q, hold_cnt_d;
`endif

    logic [SEL_W-1:0]   pick;
    logic               pick_any;
    logic               rel, to_grant, to_guard, to_idle;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (pick_any)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        out_en_d    = out_en_q;
        busy_d      = busy_q;
        last_d      = last_q;
        guard_cnt_d = guard_cnt_q;
`ifdef MUX4_RR_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        rel         = 1'b0;
        to_grant    = 1'b0;
        to_guard    = 1'b0;
        to_idle     = 1'b0;

        case (state_q)
            IDLE: to_grant = pick_any;
            GRANT: begin
                rel = !req[last_q];
`ifdef MUX4_RR_TIMEOUT_EN
                if (hold_cnt_q < HOLD_MAX) hold_cnt_d = hold_cnt_q + 8'd1;
                if (hold_cnt_q == HOLD_LAST) rel = 1'b1;
`endif
                if (rel) begin
                    // With no guard time the handoff happens on the release edge.
                    if (GUARD_CYCLES == 0) begin
                        to_grant = pick_any;
                        to_idle  = !pick_any;
                    end else begin
                        to_guard = 1'b1;
                    end
                end
            end
            GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    to_grant = pick_any;
                    to_idle  = !pick_any;
                end else begin
                    guard_cnt_d = guard_cnt_q + 4'd1;
                end
            end
            default: to_idle = 1'b1;
        endcase

        // sel only moves here, on the edge that enters GRANT.
        if (to_grant) begin
            state_d  = GRANT;
            gnt_d    = onehot(pick);
            sel_d    = pick;
            out_en_d = 1'b1;
            busy_d   = 1'b1;
            last_d   = pick;
`ifdef MUX4_RR_TIMEOUT_EN
            hold_cnt_d = 8'd0;
`endif
        end else if (to_guard) begin
            state_d     = GUARD;
            gnt_d       = '0;
            out_en_d    = 1'b0;
            busy_d      = 1'b1;
            guard_cnt_d = 4'd0;
        end else if (to_idle) begin
            state_d  = IDLE;
            gnt_d    = '0;
            out_en_d = 1'b0;
            busy_d   = 1'b0;
        end
    end

    // State, counters and output registers; last=3 so source 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            out_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= SEL_W'(NUM_SRC - 1);
            guard_cnt_q <= 4'd0;
`ifdef MUX4_RR_TIMEOUT_EN
            hold_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            out_en_q    <= out_en_d;
            busy_q      <= busy_d;
            last_q      <= last_d;
            guard_cnt_q <= guard_cnt_d;
`ifdef MUX4_RR_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign sel    = sel_q;
    assign out_en = out_en_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: three instances with different guard/hold
// settings, each compared every cycle against a behavioural model.
module tb_mux4_rr_scheduler;

`ifdef MUX4_RR_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    localparam int MH [3] = '{64, 6, 4};
    localparam int GC [3] = '{2, 0, 2};

    logic       clk;
    logic       rst_n;
    logic [3:0] rq  [3];
    logic [3:0] gnt [3];
    logic [1:0] sel [3];
    logic       oen [3];
    logic       bsy [3];

    int n_chk = 0;
    int n_err = 0;

    mux4_rr_scheduler #(.MAX_HOLD(64), .GUARD_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(rq[0]), .gnt(gnt[0]), .sel(sel[0]), .out_en(oen[0]), .busy(bsy[0]));
    mux4_rr_scheduler #(.MAX_HOLD(6), .GUARD_CYCLES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(rq[1]), .gnt(gnt[1]), .sel(sel[1]), .out_en(oen[1]), .busy(bsy[1]));
    mux4_rr_scheduler #(.MAX_HOLD(4), .GUARD_CYCLES(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .req(rq[2]), .gnt(gnt[2]), .sel(sel[2]), .out_en(oen[2]), .busy(bsy[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: owner=-1 means nobody holds the line; guard_left counts the
    // remaining dead cycles; held counts completed grant cycles.
    typedef struct {
        int owner;
        int last;
        int sel;
        int guard_left;
        int held;
    } mdl_t;

    mdl_t m [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t s;
        s.owner = -1; s.last = 3; s.sel = 0; s.guard_left = 0; s.held = 0;
        return s;
    endfunction

    function automatic int rr(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    function automatic mdl_t mstep(input mdl_t s0, input logic [3:0] r, input int mh, input int g);
        mdl_t s;
        int   p;
        s = s0;
        p = -1;
        if (s.owner >= 0) begin
            s.held++;
            if (!r[s.owner] || (TO && s.held >= mh)) begin
                s.owner = -1;
                if (g > 0) s.guard_left = g;
                else p = rr(r, s.last);
            end
        end else if (s.guard_left > 0) begin
            s.guard_left--;
            if (s.guard_left == 0) p = rr(r, s.last);
        end else begin
            p = rr(r, s.last);
        end
        if (p >= 0) begin
            s.owner = p; s.last = p; s.sel = p; s.held = 0;
        end
        return s;
    endfunction

    function automatic logic [7:0] mexp(input mdl_t s);
        logic [3:0] g;
        g = (s.owner >= 0) ? 4'(1 << s.owner) : 4'h0;
        return {g, 2'(s.sel), s.owner >= 0, (s.owner >= 0) || (s.guard_left > 0)};
    endfunction

    // One clock: drive requests, step models on the same edge, check #1 later.
    task automatic cyc(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
        rq[0] = r0; rq[1] = r1; rq[2] = r2;
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = mstep(m[i], rq[i], MH[i], GC[i]);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("model%0d", i), {gnt[i], sel[i], oen[i], bsy[i]}, mexp(m[i]));
    endtask

    function automatic logic [3:0] rot_req(input int i);
        if (m[i].owner >= 0 && m[i].held == 4) return 4'hF & ~4'(1 << m[i].owner);
        return 4'hF;
    endfunction

    initial begin
        int         seq [$];
        int         gap, run, exp_own, cnt2 [3];
        logic       prev_en, prev_b [3];
        logic [1:0] prev_sel;
        logic [3:0] sp;

        // Reset state
        rst_n = 1'b0;
        rq[0] = 4'hF; rq[1] = 4'hF; rq[2] = 4'hF;
        for (int i = 0; i < 3; i++) m[i] = mreset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("reset", {gnt[i], sel[i], oen[i], bsy[i]}, 8'h00);
        rst_n = 1'b1;

        // First grant after reset goes to source 0
        cyc(4'hF, 4'hF, 4'hF);
        chk("first_gnt", {gnt[0], sel[0], oen[0]}, {4'b0001, 2'd0, 1'b1});

        // Rotation on instance A: expect 0,1,2,3,0 with 2 dead cycles between
        seq.push_back(int'(sel[0]));
        prev_en = oen[0]; prev_sel = sel[0]; gap = 0;
        for (int c = 0; c < 120 && seq.size() < 5; c++) begin
            cyc(rot_req(0), rot_req(1), rot_req(2));
            if (!oen[0]) gap++;
            else if (!prev_en) begin
                chk("rot_gap", gap, 2);
                seq.push_back(int'(sel[0]));
                gap = 0;
            end else chk("sel_stable", sel[0], prev_sel);
            prev_en = oen[0]; prev_sel = sel[0];
        end
        chk("rot_count", seq.size(), 5);
        for (int i = 0; i < seq.size(); i++) chk("rot_order", seq[i], i % 4);

        // Sparse: only source 2 pulses; every pulse gets exactly one grant
        repeat (3) cyc(4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin cnt2[i] = 0; prev_b[i] = 1'b0; end
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 4 + ((p % 2 == 0) ? 0 : 2); c++) begin
                sp = (c < ((p % 2 == 0) ? 3 : 1)) ? 4'h0 : 4'h4;
                if (p % 2 == 0) sp = (c < 1) ? 4'h0 : 4'h4;
                cyc(sp, sp, sp);
                for (int i = 0; i < 3; i++) begin
                    chk("sparse_other", gnt[i] & 4'b1011, 4'h0);
                    if (gnt[i][2] && !prev_b[i]) cnt2[i]++;
                    prev_b[i] = gnt[i][2];
                end
            end
            repeat (3) begin
                cyc(4'h0, 4'h0, 4'h0);
                for (int i = 0; i < 3; i++) prev_b[i] = gnt[i][2];
            end
        end
        for (int i = 0; i < 3; i++) chk("sparse_grants", cnt2[i], 6);

        // Zero-guard handoff on instance B: owner 1 drops as req[3] rises
        for (int c = 0; c < 10 && gnt[1] != 4'b0010; c++) cyc(4'h0, 4'b0010, 4'h0);
        chk("handoff_setup", gnt[1], 4'b0010);
        cyc(4'h0, 4'b1000, 4'h0);
        chk("handoff", {gnt[1], sel[1], oen[1]}, {4'b1000, 2'd3, 1'b1});

        // Async reset while source 2 owns instance A
        for (int c = 0; c < 10 && gnt[0] != 4'b0100; c++) cyc(4'b0100, 4'h0, 4'h0);
        chk("mrst_setup", gnt[0], 4'b0100);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("mrst", {gnt[i], sel[i], oen[i], bsy[i]}, 8'h00);
        for (int i = 0; i < 3; i++) m[i] = mreset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4'hF, 4'hF, 4'b0011);
        chk("mrst_first", gnt[0], 4'b0001);

        // Hold timeout on instance C with req=0011
        chk("to_start", sel[2], 2'd0);
        run = 1; exp_own = 0; prev_en = oen[2];
        for (int c = 0; c < 30; c++) begin
            cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'b0011);
            if (TO) begin
                if (oen[2]) begin
                    if (!prev_en) begin
                        exp_own ^= 1;
                        chk("to_owner", sel[2], 2'(exp_own));
                        run = 0;
                    end
                    run++;
                end else if (prev_en) chk("to_run", run, 4);
                prev_en = oen[2];
            end else begin
                chk("hold_forever", gnt[2], 4'b0001);
            end
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            logic [3:0] r [3];
            for (int i = 0; i < 3; i++)
                r[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : rq[i];
            cyc(r[0], r[1], r[2]);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mux4_rr_scheduler.md
Name: mux4_rr_scheduler

Overview:
- Round-robin scheduler that shares one 4-input, 1-bit mux output line between four requesting sources.
- Drives the mux 2-bit select, a one-hot grant back to each source, and an output-enable that gates the muxed line.
- Inserts guard cycles between owners so the shared line never switches source while it is enabled.
- Sits between the four pixel-stream sources and the shared mux in the vision pipeline.

Parameters:
- MAX_HOLD, 64: maximum consecutive GRANT cycles for one owner; range 1..255.
- GUARD_CYCLES, 2: idle cycles between owners with out_en low; range 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  4  level request per source, bit i = source i.
- gnt  out  4  one-hot grant; all-zero when no owner.
- sel  out  2  mux select; binary index of the current or most recent owner.
- out_en  out  1  high only in GRANT; qualifies the muxed line.
- busy  out  1  high in GRANT or GUARD.

Behaviour:
- Reset values: gnt=0, sel=2'b00, out_en=0, busy=0, state=IDLE, hold_cnt=0, guard_cnt=0, last=3 (so source 0 wins first).
- All outputs are registered.
- States are IDLE, GRANT and GUARD.
- Arbitration pick: combinational search from index last+1 mod 4 upward, wrapping after 3; the first set req bit wins.
- IDLE -> GRANT when any req bit is set at a clock edge.
  - On that edge: gnt=onehot(pick), sel=pick, out_en=1, busy=1, last=pick, hold_cnt=0.
  - Latency from req sampled high to gnt high is 1 cycle.
- GRANT, per cycle:
  - hold_cnt increments, saturating at MAX_HOLD.
  - If req[owner]=0, go to GUARD: gnt=0, out_en=0, guard_cnt=0.
  - sel holds its value through GUARD and IDLE.
- GUARD behaviour:
  - Stays for exactly GUARD_CYCLES cycles.
  - Then goes to GRANT (new pick) if any req is set, else IDLE (busy=0).
  - If GUARD_CYCLES=0, GRANT goes directly to GRANT with the new pick, or to IDLE, on the release edge.
  - sel never changes while out_en=1; sel changes only on the edge that enters GRANT.
- Simultaneous events:
  - Owner drops req while another source raises req in the same cycle: go to GUARD first; the other source is picked at GUARD exit.
  - Owner releases, and its own req is the only one set at GUARD exit: the same source is re-granted, because the pick wraps back to last.
  - Non-owner req toggles during GRANT: ignored; requests are not latched and are sampled only at pick time.
- Counter widths: hold_cnt is 8 bits; guard_cnt is 4 bits. No wrap is possible because both counters saturate or are reset on entry.
- Reset asserted mid-operation: immediately returns all outputs and state to the reset values, independent of clk. Arbitration resumes from source 0.

Optional Feature:
- Macro: MUX4_RR_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt reaches MAX_HOLD-1 with req[owner] still high, the next edge forces GUARD exactly as a release does.
  - The preempted source must re-win arbitration; last=owner, so it goes to the back of the rotation.
- Not defined:
  - The owner keeps the grant indefinitely while its req is high.
  - hold_cnt is not implemented.

Decomposition:
- Shared header package contents:
  - State encoding localparams: IDLE=2'd0, GRANT=2'd1, GUARD=2'd2.
  - NUM_SRC=4.
  - SEL_W=2.
- Natural sub-module: rr_pick4.
  - Inputs: req[3:0], last[1:0].
  - Outputs: pick[1:0], any.
  - Purely combinational; the rotate-and-priority-encode logic lives here.
- FSM, counters and output registers stay in the top.

Test Plan:
- Reset/first grant: release rst_n with req=4'b1111 -> gnt=4'b0001, sel=0, out_en=1, one cycle after the first sampled edge.
- Rotation (GUARD_CYCLES=2):
  - Stimulus: all req held; each owner drops its req for 1 cycle after 5 grant cycles.
  - Grant order 0,1,2,3,0.
  - Exactly 2 cycles with out_en=0 between owners.
  - sel is stable whenever out_en=1.
- Sparse requests: only req[2] pulses high and low repeatedly -> source 2 is re-granted each time after GUARD; gnt is never set for other bits.
- Simultaneous handoff (GUARD_CYCLES=0):
  - Stimulus: owner 1 drops req on the same edge that req[3] rises.
  - Next cycle gnt=4'b1000, sel=3, with no idle gap.
- Timeout (MUX4_RR_TIMEOUT_EN, MAX_HOLD=4):
  - Stimulus: req=4'b0011 held high.
  - Owner 0 holds 4 cycles, GUARD, then owner 1 holds 4 cycles, alternating.
  - Without the macro, owner 0 holds forever.
- Mid-operation reset: assert rst_n low during GRANT of source 2 -> gnt=0, out_en=0, busy=0, sel=0 asynchronously; after release, the first grant goes to source 0 if req[0] is set.
